sdram_cmd_sequencer: RTL and testbench
======================================

# sdram_cmd_sequencer

Registered, parametrised SDRAM command issuer that replaces the purely combinational command decoder. It accepts abstract 4-bit commands over a valid/ready handshake. It drives registered SDRAM pins one cycle after acceptance, enforces minimum command-to-command gaps, tracks open rows per bank, and holds the device in NOP or low-power between commands. It sits between the controller FSM and the SDRAM pads.

## Interface
- ROW_W, 12, row address width; also the width of `addr`
- COL_W, 8, column address width (≤ ROW_W−2)
- BA_W, 2, bank address width; NBANK = 2**BA_W
- DQM_W, 2, byte-mask width
- AP_BIT, 10, address bit carrying auto-precharge / all-banks
- T_RCD, 2, ACT→READ/WRIT gap in cycles (≥1)
- T_RP, 2, PRE/PALL/READA/WRITA→next gap (≥1)
- T_RFC, 7, REF→next gap (≥1)
- T_MRD, 2, MRS→next gap (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command may be accepted this cycle
- cmd  in  4  command code (shared package encoding)
- cmd_addr  in  BA_W+ROW_W+COL_W  {bank, row, col}
- cmd_be  in  DQM_W  byte mask for READ/WRIT/ACT
- mrs_val  in  ROW_W  mode register value
- cke, cs_n, ras_n, cas_n, we_n  out  1 each  registered SDRAM controls
- ba  out  BA_W  registered bank
- addr  out  ROW_W  registered address
- dqm  out  DQM_W  registered mask
- bank_open  out  NBANK  per-bank row-open flags
- cmd_err  out  1  one-cycle pulse on an illegal command

## Operation
- Accept on `cmd_valid && cmd_ready`. `cmd_ready` = (`wait_cnt` == 0) && !rst.
- Pin decode per command follows the existing encoding:
  - ACT drives the row on `addr` and `cmd_be` on `dqm`.
  - READ/WRIT drive the column zero-extended. READA/WRITA also set `addr[AP_BIT]`. Both drive `cmd_be` on `dqm`.
  - PRE drives `ba` = bank and `addr` = 0.
  - PALL drives `addr` with only `AP_BIT` set.
  - MRS drives `ba` = 0 and `addr` = `mrs_val`.
  - REF drives cs_n/ras_n/cas_n low, we_n high, `ba` = 0.
- Bank tracking:
  - ACT sets `bank_open[ba]`.
  - PRE, READA and WRITA clear `bank_open[ba]`. PALL clears all banks.
- Illegal commands. On each of these, pins emit NOP, `cmd_err` pulses, and `bank_open` and `wait_cnt` are unchanged:
  - READ/READA/WRIT/WRITA to a closed bank
  - ACT to an open bank
  - REF while any bank is open
- Gap loading: on a legal accept, `wait_cnt` ← gap−1.
  - ACT uses T_RCD.
  - PRE, PALL, READA and WRITA use T_RP.
  - REF uses T_RFC.
  - MRS uses T_MRD.
  - Everything else uses 1.
- `wait_cnt` decrements to 0 and saturates there.
- Low-power register `lp`:
  - SELF or SUP sets it. REC or NOP clears it.
  - While `lp` = 1, idle cycles drive `cke` = 0 and all other pins as NOP.
  - Any other command while `lp` = 1 is illegal.
- DESL drives `cs_n` = 1 and `cke` = 0.
- Cycles with no accept:
  - `lp` = 0: NOP, i.e. `cke` 1, `cs_n` 0, ras/cas/we 1, `dqm` all ones, `ba`/`addr` hold their last value.
  - `lp` = 1: as above, but `cke` 0.
- Unused code 4'b1111 is treated as NOP.

## Timing
- Latency: pins reflect an accepted command on the first rising edge after acceptance. They revert to idle the following cycle.
- With gap G, the next accept is possible at the earliest G cycles after the previous one. G = 1 allows back-to-back accepts.
- `cmd_err` is asserted in the same cycle as the NOP it replaces (one cycle after the accept).
- Reset (async assert, sync release) sets:
  - `cke` 0, `cs_n` 1, `ras_n`/`cas_n`/`we_n` 1, `ba` 0, `addr` 0, `dqm` all ones
  - `bank_open` 0, `cmd_err` 0, `wait_cnt` 0, `lp` 0
  - `cmd_ready` 0 during reset and 1 in the first cycle after release
- Reset mid-gap discards the gap and all bank state immediately.
- A command held valid while `cmd_ready` = 0 must stay stable. It is accepted in the first cycle that `wait_cnt` reaches 0.

## Structure
- Shared package `sdram_pkg` holds:
  - the CMD_* localparam encodings (4-bit)
  - a `sdram_pins_t` struct {cke, cs_n, ras_n, cas_n, we_n}
  - a `decode_pins(cmd)` function
  - a `gap_of(cmd)` function
- One natural sub-module, `sdram_bank_tracker`. It holds the `bank_open` register, the legality check and the clear/set logic, parametrised by BA_W.
- The top level holds the handshake, `wait_cnt`, `lp` and the output registers.

## Test plan
- Reset, then ACT to bank 1, row 0x2A5 → next cycle ras_n 0, cas_n 1, we_n 1, ba 1, addr 0x2A5, bank_open 4'b0010; cmd_ready low for 1 cycle (T_RCD = 2).
- Then READA to bank 1, col 0x3C, be 2'b01 → addr 0x43C, dqm 01, cas_n 0; bank_open 0; next accept at earliest 2 cycles later.
- READ to closed bank 2 → pins NOP, cmd_err pulses 1 cycle, bank_open unchanged, cmd_ready stays 1.
- PALL with banks 0 and 3 open, then REF → addr 0x400 with bank_open 0; REF accepted 2 cycles later; cmd_ready low for 6 cycles after REF.
- MRS with mrs_val 0x027 → ba 0, addr 0x027, all control low; SELF → cke 0 on idle cycles; ACT is rejected with cmd_err; NOP → cke 1.
- Assert rst during the REF gap (wait_cnt = 4) → outputs take reset values asynchronously; cmd_ready is 1 in the first cycle after release.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encoding, pin bundle type and per-command helpers.
package sdram_pkg;

  localparam logic [3:0] CMD_DESL   = 4'd0;
  localparam logic [3:0] CMD_NOP    = 4'd1;
  localparam logic [3:0] CMD_MRS    = 4'd2;
  localparam logic [3:0] CMD_ACT    = 4'd3;
  localparam logic [3:0] CMD_READ   = 4'd4;
  localparam logic [3:0] CMD_READA  = 4'd5;
  localparam logic [3:0] CMD_WRIT   = 4'd6;
  localparam logic [3:0] CMD_WRITA  = 4'd7;
  localparam logic [3:0] CMD_PRE    = 4'd8;
  localparam logic [3:0] CMD_PALL   = 4'd9;
  localparam logic [3:0] CMD_REF    = 4'd10;
  localparam logic [3:0] CMD_SELF   = 4'd11;
  localparam logic [3:0] CMD_SUP    = 4'd12;
  localparam logic [3:0] CMD_REC    = 4'd13;
  // Codes 14 and 15 carry no command and behave exactly like NOP.
  localparam logic [3:0] CMD_RSVD   = 4'd14;
  localparam logic [3:0] CMD_UNUSED = 4'd15;

  typedef struct packed {
    logic cke;
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } sdram_pins_t;

  localparam sdram_pins_t PINS_NOP = '{cke: 1'b1, cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};
  localparam sdram_pins_t PINS_RST = '{cke: 1'b0, cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};

  // Control pin pattern for a legal accepted command.
  function automatic sdram_pins_t decode_pins(input logic [3:0] cmd);
    sdram_pins_t p;
    p = PINS_NOP;
    case (cmd)
      CMD_DESL:              begin p.cke = 1'b0; p.cs_n = 1'b1; end
      CMD_MRS:               begin p.ras_n = 1'b0; p.cas_n = 1'b0; p.we_n = 1'b0; end
      CMD_ACT:               p.ras_n = 1'b0;
      CMD_READ, CMD_READA:   p.cas_n = 1'b0;
      CMD_WRIT, CMD_WRITA:   begin p.cas_n = 1'b0; p.we_n = 1'b0; end
      CMD_PRE, CMD_PALL:     begin p.ras_n = 1'b0; p.we_n = 1'b0; end
      CMD_REF:               begin p.ras_n = 1'b0; p.cas_n = 1'b0; end
      CMD_SELF:              begin p.cke = 1'b0; p.ras_n = 1'b0; p.cas_n = 1'b0; end
      CMD_SUP:               p.cke = 1'b0;
      default:               ;
    endcase
    return p;
  endfunction

  // Minimum cycles from this command's accept to the next accept.
  function automatic int gap_of(input logic [3:0] cmd, input int t_rcd, input int t_rp,
                                input int t_rfc, input int t_mrd);
    int g;
    case (cmd)
      CMD_ACT:                                g = t_rcd;
      CMD_PRE, CMD_PALL, CMD_READA, CMD_WRITA: g = t_rp;
      CMD_REF:                                g = t_rfc;
      CMD_MRS:                                g = t_mrd;
      default:                                g = 1;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// Per-bank open-row flags and command legality (bank state and low-power).
module sdram_bank_tracker import sdram_pkg::*; #(
  parameter int BA_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept_i,
  input  logic [3:0]            cmd_i,
  input  logic [BA_W-1:0]       bank_i,
  input  logic                  lp_i,
  output logic                  legal_o,
  output logic [2**BA_W-1:0]    bank_open_o
);

  localparam int NBANK = 2**BA_W;

  logic [NBANK-1:0] open_q, open_d;

  // Legality: low-power only admits power-state commands; row commands need matching bank state.
  always_comb begin
    legal_o = 1'b1;
    if (lp_i) begin
      legal_o = (cmd_i == CMD_SELF) || (cmd_i == CMD_SUP) || (cmd_i == CMD_REC) ||
                (cmd_i == CMD_NOP)  || (cmd_i == CMD_RSVD) || (cmd_i == CMD_UNUSED);
    end else begin
      case (cmd_i)
        CMD_READ, CMD_READA, CMD_WRIT, CMD_WRITA: legal_o = open_q[bank_i];
        CMD_ACT:                                  legal_o = !open_q[bank_i];
        CMD_REF:                                  legal_o = (open_q == '0);
        default:                                  ;
      endcase
    end
  end

  // Open/close rows on legal accepts only.
  always_comb begin
    open_d = open_q;
    if (accept_i && legal_o) begin
      case (cmd_i)
        CMD_ACT:                       open_d[bank_i] = 1'b1;
        CMD_PRE, CMD_READA, CMD_WRITA: open_d[bank_i] = 1'b0;
        CMD_PALL:                      open_d = '0;
        default:                       ;
      endcase
    end
  end

  // Bank state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) open_q <= '0;
    else     open_q <= open_d;
  end

  assign bank_open_o = open_q;

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// Registered SDRAM command issuer: handshake, gap counter, low-power state, pin registers.
module sdram_cmd_sequencer import sdram_pkg::*; #(
  parameter int ROW_W  = 12,
  parameter int COL_W  = 8,
  parameter int BA_W   = 2,
  parameter int DQM_W  = 2,
  parameter int AP_BIT = 10,
  parameter int T_RCD  = 2,
  parameter int T_RP   = 2,
  parameter int T_RFC  = 7,
  parameter int T_MRD  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd,
  input  logic [BA_W+ROW_W+COL_W-1:0] cmd_addr,
  input  logic [DQM_W-1:0]          cmd_be,
  input  logic [ROW_W-1:0]          mrs_val,
  output logic                      cke,
  output logic                      cs_n,
  output logic                      ras_n,
  output logic                      cas_n,
  output logic                      we_n,
  output logic [BA_W-1:0]           ba,
  output logic [ROW_W-1:0]          addr,
  output logic [DQM_W-1:0]          dqm,
  output logic [2**BA_W-1:0]        bank_open,
  output logic                      cmd_err
);

  localparam int GMAX12 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int GMAX34 = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int GMAX   = (GMAX12 > GMAX34) ? GMAX12 : GMAX34;
  localparam int WAIT_W = ($clog2(GMAX) < 1) ? 1 : $clog2(GMAX);

  logic [BA_W-1:0]   bank;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              accept, legal;

  sdram_pins_t       pins_q, pins_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [ROW_W-1:0]  addr_q, addr_d;
  logic [DQM_W-1:0]  dqm_q, dqm_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              lp_q, lp_d;

  assign bank      = cmd_addr[BA_W+ROW_W+COL_W-1 -: BA_W];
  assign row       = cmd_addr[ROW_W+COL_W-1 -: ROW_W];
  assign col       = cmd_addr[COL_W-1:0];
  assign cmd_ready = (wait_q == '0) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  sdram_bank_tracker #(.BA_W(BA_W)) u_banks (
    .clk         (clk),
    .rst         (rst),
    .accept_i    (accept),
    .cmd_i       (cmd),
    .bank_i      (bank),
    .lp_i        (lp_q),
    .legal_o     (legal),
    .bank_open_o (bank_open)
  );

  // Next pin image: idle NOP by default, decoded command on a legal accept, NOP+err otherwise.
  always_comb begin
    pins_d     = PINS_NOP;
    pins_d.cke = !lp_q;
    ba_d       = ba_q;
    addr_d     = addr_q;
    dqm_d      = '1;
    err_d      = 1'b0;
    lp_d       = lp_q;
    wait_d     = (wait_q != '0) ? wait_q - WAIT_W'(1) : '0;
    if (accept) begin
      if (!legal) begin
        err_d = 1'b1;
      end else begin
        pins_d = decode_pins(cmd);
        wait_d = WAIT_W'(gap_of(cmd, T_RCD, T_RP, T_RFC, T_MRD) - 1);
        case (cmd)
          CMD_ACT: begin
            ba_d = bank; addr_d = row; dqm_d = cmd_be;
          end
          CMD_READ, CMD_WRIT: begin
            ba_d = bank; addr_d = {{(ROW_W-COL_W){1'b0}}, col}; dqm_d = cmd_be;
          end
          CMD_READA, CMD_WRITA: begin
            ba_d = bank; addr_d = {{(ROW_W-COL_W){1'b0}}, col}; addr_d[AP_BIT] = 1'b1;
            dqm_d = cmd_be;
          end
          CMD_PRE: begin
            ba_d = bank; addr_d = '0;
          end
          CMD_PALL: begin
            ba_d = bank; addr_d = '0; addr_d[AP_BIT] = 1'b1;
          end
          CMD_MRS: begin
            ba_d = '0; addr_d = mrs_val;
          end
          CMD_REF:                               ba_d = '0;
          CMD_SELF, CMD_SUP:                     lp_d = 1'b1;
          CMD_NOP, CMD_REC, CMD_RSVD, CMD_UNUSED: lp_d = 1'b0;
          default:                               ;
        endcase
      end
    end
  end

  // Output, gap and low-power registers; reset drops everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pins_q <= PINS_RST;
      ba_q   <= '0;
      addr_q <= '0;
      dqm_q  <= '1;
      err_q  <= 1'b0;
      wait_q <= '0;
      lp_q   <= 1'b0;
    end else begin
      pins_q <= pins_d;
      ba_q   <= ba_d;
      addr_q <= addr_d;
      dqm_q  <= dqm_d;
      err_q  <= err_d;
      wait_q <= wait_d;
      lp_q   <= lp_d;
    end
  end

  assign cke     = pins_q.cke;
  assign cs_n    = pins_q.cs_n;
  assign ras_n   = pins_q.ras_n;
  assign cas_n   = pins_q.cas_n;
  assign we_n    = pins_q.we_n;
  assign ba      = ba_q;
  assign addr    = addr_q;
  assign dqm     = dqm_q;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Bench for sdram_cmd_sequencer: directed vector table, reset-in-gap sequence, random vs. model.
module tb_sdram_cmd_sequencer;
  import sdram_pkg::*;

  logic        clk, rst, cmd_valid, cmd_ready;
  logic [3:0]  cmd;
  logic [21:0] cmd_addr;
  logic [1:0]  cmd_be;
  logic [11:0] mrs_val;
  logic        cke, cs_n, ras_n, cas_n, we_n, cmd_err;
  logic [1:0]  ba, dqm;
  logic [11:0] addr;
  logic [3:0]  bank_open;

  int n_chk = 0;
  int n_fail = 0;

  sdram_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .mrs_val(mrs_val), .cke(cke), .cs_n(cs_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr), .dqm(dqm),
    .bank_open(bank_open), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  c;
    logic [1:0]  bk;
    logic [11:0] row;
    logic [7:0]  col;
    logic [1:0]  be;
    logic [11:0] mrs;
    logic        rdy;   // cmd_ready before the edge
    logic [4:0]  ctl;   // {cke,cs_n,ras_n,cas_n,we_n} after the edge
    logic [1:0]  eba;
    logic [11:0] eaddr;
    logic [1:0]  edqm;
    logic [3:0]  ebo;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [3:0] c, input logic [1:0] bk, input logic [11:0] row,
                     input logic [7:0] col, input logic [1:0] be, input logic [11:0] mrs,
                     input logic rdy, input logic [4:0] ctl, input logic [1:0] eba,
                     input logic [11:0] eaddr, input logic [1:0] edqm, input logic [3:0] ebo,
                     input logic eerr);
    vec_t t;
    t.v = v; t.c = c; t.bk = bk; t.row = row; t.col = col; t.be = be; t.mrs = mrs;
    t.rdy = rdy; t.ctl = ctl; t.eba = eba; t.eaddr = eaddr; t.edqm = edqm; t.ebo = ebo; t.eerr = eerr;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bank flags as a bit array, lp flag, and the earliest cycle index
  // at which the next accept is allowed.
  bit          m_open[4];
  bit          m_lp;
  int          m_ready_at, cyc;
  logic [1:0]  m_ba;
  logic [11:0] m_addr;
  logic [4:0]  x_ctl;
  logic [1:0]  x_dqm;
  logic        x_err;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
    m_lp = 1'b0; m_ready_at = 0; cyc = 0; m_ba = '0; m_addr = '0;
  endtask

  function automatic logic model_ready();
    return cyc >= m_ready_at;
  endfunction

  function automatic logic [3:0] model_bo();
    return {m_open[3], m_open[2], m_open[1], m_open[0]};
  endfunction

  task automatic model_step(input vec_t t);
    bit acc, ok, any;
    int gap;
    acc = t.v && model_ready();
    x_ctl = m_lp ? 5'b00111 : 5'b10111;
    x_dqm = 2'b11;
    x_err = 1'b0;
    if (acc) begin
      any = m_open[0] | m_open[1] | m_open[2] | m_open[3];
      if (m_lp) ok = (t.c == CMD_SELF) || (t.c == CMD_SUP) || (t.c == CMD_REC) ||
                     (t.c == CMD_NOP) || (t.c > 4'd13);
      else if (t.c == CMD_ACT) ok = !m_open[t.bk];
      else if (t.c >= CMD_READ && t.c <= CMD_WRITA) ok = m_open[t.bk];
      else if (t.c == CMD_REF) ok = !any;
      else ok = 1'b1;
      if (!ok) x_err = 1'b1;
      else begin
        gap = 1;
        case (t.c)
          CMD_ACT: begin
            x_ctl = 5'b10011; m_ba = t.bk; m_addr = t.row; x_dqm = t.be; m_open[t.bk] = 1'b1; gap = 2;
          end
          CMD_READ:  begin x_ctl = 5'b10101; m_ba = t.bk; m_addr = {4'h0, t.col}; x_dqm = t.be; end
          CMD_READA: begin
            x_ctl = 5'b10101; m_ba = t.bk; m_addr = {4'h4, t.col}; x_dqm = t.be; m_open[t.bk] = 1'b0; gap = 2;
          end
          CMD_WRIT:  begin x_ctl = 5'b10100; m_ba = t.bk; m_addr = {4'h0, t.col}; x_dqm = t.be; end
          CMD_WRITA: begin
            x_ctl = 5'b10100; m_ba = t.bk; m_addr = {4'h4, t.col}; x_dqm = t.be; m_open[t.bk] = 1'b0; gap = 2;
          end
          CMD_PRE:   begin x_ctl = 5'b10010; m_ba = t.bk; m_addr = 12'h000; m_open[t.bk] = 1'b0; gap = 2; end
          CMD_PALL:  begin
            x_ctl = 5'b10010; m_ba = t.bk; m_addr = 12'h400; gap = 2;
            for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
          end
          CMD_MRS:   begin x_ctl = 5'b10000; m_ba = 2'd0; m_addr = t.mrs; gap = 2; end
          CMD_REF:   begin x_ctl = 5'b10001; m_ba = 2'd0; gap = 7; end
          CMD_SELF:  begin x_ctl = 5'b00001; m_lp = 1'b1; end
          CMD_SUP:   begin x_ctl = 5'b00111; m_lp = 1'b1; end
          CMD_DESL:  x_ctl = 5'b01111;
          default:   begin x_ctl = 5'b10111; m_lp = 1'b0; end
        endcase
        m_ready_at = cyc + gap;
      end
    end
    cyc++;
  endtask

  // One clock: drive at +1 after the edge, check ready, clock, check registered outputs.
  task automatic step(input bit use_tbl, input vec_t t);
    cmd_valid = t.v; cmd = t.c; cmd_addr = {t.bk, t.row, t.col}; cmd_be = t.be; mrs_val = t.mrs;
    #1;
    check("cmd_ready", cmd_ready, use_tbl ? t.rdy : model_ready());
    model_step(t);
    @(posedge clk); #1;
    check("ctl", {cke, cs_n, ras_n, cas_n, we_n}, use_tbl ? t.ctl : x_ctl);
    check("ba", ba, use_tbl ? t.eba : m_ba);
    check("addr", addr, use_tbl ? t.eaddr : m_addr);
    check("dqm", dqm, use_tbl ? t.edqm : x_dqm);
    check("bank_open", bank_open, use_tbl ? t.ebo : model_bo());
    check("cmd_err", cmd_err, use_tbl ? t.eerr : x_err);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctl"}, {cke, cs_n, ras_n, cas_n, we_n}, 5'b01111);
    check({tag, "_ba"}, ba, 2'd0);
    check({tag, "_addr"}, addr, 12'h000);
    check({tag, "_dqm"}, dqm, 2'b11);
    check({tag, "_bank_open"}, bank_open, 4'h0);
    check({tag, "_cmd_err"}, cmd_err, 1'b0);
    check({tag, "_ready"}, cmd_ready, 1'b0);
  endtask

  vec_t idle, cur;
  bit   pend, r;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd = CMD_NOP; cmd_addr = '0; cmd_be = '0; mrs_val = '0;
    idle = '{v: 1'b0, c: CMD_NOP, bk: 2'd0, row: 12'h0, col: 8'h0, be: 2'b00, mrs: 12'h0,
             rdy: 1'b0, ctl: 5'b0, eba: 2'd0, eaddr: 12'h0, edqm: 2'b0, ebo: 4'h0, eerr: 1'b0};

    // v  cmd        bk row     col    be     mrs     rdy ctl       ba addr    dqm    bo     err
    add(1, CMD_ACT,   1, 12'h2A5, 8'h00, 2'b10, 12'h0,  1, 5'b10011, 1, 12'h2A5, 2'b10, 4'h2, 0);
    add(1, CMD_READA, 1, 12'h000, 8'h3C, 2'b01, 12'h0,  0, 5'b10111, 1, 12'h2A5, 2'b11, 4'h2, 0);
    add(1, CMD_READA, 1, 12'h000, 8'h3C, 2'b01, 12'h0,  1, 5'b10101, 1, 12'h43C, 2'b01, 4'h0, 0);
    add(1, CMD_READ,  2, 12'h000, 8'h05, 2'b00, 12'h0,  0, 5'b10111, 1, 12'h43C, 2'b11, 4'h0, 0);
    add(1, CMD_READ,  2, 12'h000, 8'h05, 2'b00, 12'h0,  1, 5'b10111, 1, 12'h43C, 2'b11, 4'h0, 1);
    add(1, CMD_ACT,   0, 12'h111, 8'h00, 2'b11, 12'h0,  1, 5'b10011, 0, 12'h111, 2'b11, 4'h1, 0);
    add(1, CMD_ACT,   3, 12'h0F0, 8'h00, 2'b00, 12'h0,  0, 5'b10111, 0, 12'h111, 2'b11, 4'h1, 0);
    add(1, CMD_ACT,   3, 12'h0F0, 8'h00, 2'b00, 12'h0,  1, 5'b10011, 3, 12'h0F0, 2'b00, 4'h9, 0);
    add(1, CMD_PALL,  0, 12'h000, 8'h00, 2'b00, 12'h0,  0, 5'b10111, 3, 12'h0F0, 2'b11, 4'h9, 0);
    add(1, CMD_PALL,  0, 12'h000, 8'h00, 2'b00, 12'h0,  1, 5'b10010, 0, 12'h400, 2'b11, 4'h0, 0);
    add(1, CMD_REF,   0, 12'h000, 8'h00, 2'b00, 12'h0,  0, 5'b10111, 0, 12'h400, 2'b11, 4'h0, 0);
    add(1, CMD_REF,   0, 12'h000, 8'h00, 2'b00, 12'h0,  1, 5'b10001, 0, 12'h400, 2'b11, 4'h0, 0);
    for (int i = 0; i < 6; i++)
      add(1, CMD_MRS, 0, 12'h000, 8'h00, 2'b00, 12'h027, 0, 5'b10111, 0, 12'h400, 2'b11, 4'h0, 0);
    add(1, CMD_MRS,   0, 12'h000, 8'h00, 2'b00, 12'h027, 1, 5'b10000, 0, 12'h027, 2'b11, 4'h0, 0);
    add(1, CMD_SELF,  0, 12'h000, 8'h00, 2'b00, 12'h0,  0, 5'b10111, 0, 12'h027, 2'b11, 4'h0, 0);
    add(1, CMD_SELF,  0, 12'h000, 8'h00, 2'b00, 12'h0,  1, 5'b00001, 0, 12'h027, 2'b11, 4'h0, 0);
    add(0, CMD_NOP,   0, 12'h000, 8'h00, 2'b00, 12'h0,  1, 5'b00111, 0, 12'h027, 2'b11, 4'h0, 0);
    add(1, CMD_ACT,   2, 12'h005, 8'h00, 2'b00, 12'h0,  1, 5'b00111, 0, 12'h027, 2'b11, 4'h0, 1);
    add(1, CMD_NOP,   0, 12'h000, 8'h00, 2'b00, 12'h0,  1, 5'b10111, 0, 12'h027, 2'b11, 4'h0, 0);
    add(0, CMD_NOP,   0, 12'h000, 8'h00, 2'b00, 12'h0,  1, 5'b10111, 0, 12'h027, 2'b11, 4'h0, 0);
    add(1, CMD_DESL,  0, 12'h000, 8'h00, 2'b00, 12'h0,  1, 5'b01111, 0, 12'h027, 2'b11, 4'h0, 0);
    add(0, CMD_NOP,   0, 12'h000, 8'h00, 2'b00, 12'h0,  1, 5'b10111, 0, 12'h027, 2'b11, 4'h0, 0);
    add(1, CMD_ACT,   1, 12'h003, 8'h00, 2'b11, 12'h0,  1, 5'b10011, 1, 12'h003, 2'b11, 4'h2, 0);
    add(1, CMD_WRIT,  1, 12'h000, 8'hFF, 2'b00, 12'h0,  0, 5'b10111, 1, 12'h003, 2'b11, 4'h2, 0);
    add(1, CMD_WRIT,  1, 12'h000, 8'hFF, 2'b00, 12'h0,  1, 5'b10100, 1, 12'h0FF, 2'b00, 4'h2, 0);
    add(1, CMD_PRE,   1, 12'h000, 8'h00, 2'b00, 12'h0,  1, 5'b10010, 1, 12'h000, 2'b11, 4'h0, 0);
    add(0, CMD_NOP,   0, 12'h000, 8'h00, 2'b00, 12'h0,  0, 5'b10111, 1, 12'h000, 2'b11, 4'h0, 0);
    add(1, CMD_UNUSED,0, 12'h000, 8'h00, 2'b00, 12'h0,  1, 5'b10111, 1, 12'h000, 2'b11, 4'h0, 0);

    // Power-on reset.
    #1 rst = 1'b1;
    @(posedge clk); #2;
    check_reset_state("por");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    foreach (tbl[i]) step(1'b1, tbl[i]);

    // Reset in the middle of a refresh gap.
    cur = idle; cur.v = 1'b1; cur.c = CMD_REF;
    step(1'b0, cur);
    step(1'b0, idle);
    step(1'b0, idle);
    #2 rst = 1'b1;
    #1 check_reset_state("midgap");
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check("ready_after_release", cmd_ready, 1'b1);
    model_reset();
    step(1'b0, idle);

    // Random traffic; a command that is not accepted is held stable until it is.
    pend = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!pend) begin
        cur.v   = ($urandom_range(0, 3) != 0);
        cur.c   = 4'($urandom_range(0, 15));
        cur.bk  = 2'($urandom_range(0, 3));
        cur.row = 12'($urandom);
        cur.col = 8'($urandom);
        cur.be  = 2'($urandom);
        cur.mrs = 12'($urandom);
      end
      r = model_ready();
      step(1'b0, cur);
      pend = cur.v && !r;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
